// File: rtl/uart_fifo_ctrl.sv
// Register-mapped UART with TX/RX FIFOs, runtime baud divisor, sticky error flags and a level irq.
// Define UART_PARITY_EN to add the optional parity bit (CTRL[3]=enable, CTRL[4]=odd).
module uart_fifo_ctrl #(
  parameter int DIV_RESET = 10,
  parameter int DATA_BITS = 8,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  addr,
  input  logic [31:0] data_in,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] data_out,
  output logic        tx,
  input  logic        rx,
  output logic        busy,
  output logic        irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [15:0]   DIV_INIT = 16'(DIV_RESET);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [TAW:0]  TX_ONE   = (TAW+1)'(1);
  localparam logic [RAW:0]  RX_ONE   = (RAW+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic        tx_en, rx_en, par_en, par_odd;
  logic [15:0] baud;
  logic [3:0]  irq_en;
  logic        overrun, framing_err, parity_err;

  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [TAW:0] tx_wp, tx_rp;
  logic [RAW:0] rx_wp, rx_rp;
  logic         tx_empty, tx_full, rx_empty, rx_full;

  state_t               tx_state, rx_state;
  logic [15:0]          tx_cnt, tx_div, rx_cnt, rx_div;
  logic [BW-1:0]        tx_bit, rx_bit;
  logic [DATA_BITS-1:0] tx_shift, rx_shift, tx_head;
  logic                 tx_par, tx_par_on, tx_last;
  logic                 rx_s1, rx_s2, rx_prev, rx_par_on, rx_odd, rx_pbad, rx_last;
  logic                 rx_done, rx_ferr, rx_perr;

  logic        wr_ctrl, wr_txd, wr_stat, wr_baud, wr_irqen, rd_rxd, flush;
  logic        tx_push, tx_pop, rx_push, rx_pop, overrun_set;
  logic [6:0]  status;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);

  assign wr_ctrl  = write_enable && (addr == 4'd0);
  assign wr_txd   = write_enable && (addr == 4'd1);
  assign wr_stat  = write_enable && (addr == 4'd3);
  assign wr_baud  = write_enable && (addr == 4'd4);
  assign wr_irqen = write_enable && (addr == 4'd5);
  assign rd_rxd   = read_enable  && (addr == 4'd2);
  assign flush    = wr_ctrl && data_in[2];

  assign tx_last = (tx_cnt == tx_div - 16'd1);
  assign rx_last = (rx_cnt == rx_div - 16'd1);
  assign tx_head = tx_mem[tx_rp[TAW-1:0]];

  // A frame may start from IDLE or straight out of the final STOP cycle, so frames run back to back.
  assign tx_pop  = tx_en && !tx_empty &&
                   ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_last));
  assign tx_push = wr_txd && (!tx_full || tx_pop);
  assign rx_pop  = rd_rxd && !rx_empty;
  assign rx_push = rx_done && (!rx_full || rx_pop);
  assign overrun_set = rx_done && rx_full && !rx_pop;

  assign status = {parity_err, rx_full, tx_full, framing_err, overrun, tx_empty, !rx_empty};
  assign irq    = |(status[3:0] & irq_en);
  assign busy   = (tx_state != S_IDLE) || !tx_empty;
  assign unused_bits = ^data_in[31:16];

  always_comb begin
    rd_word = 32'd0;
    case (addr)
      4'd0: rd_word = {27'd0, par_odd, par_en, 1'b0, rx_en, tx_en};
      4'd2: if (!rx_empty) rd_word = {1'b1, {(31-DATA_BITS){1'b0}}, rx_mem[rx_rp[RAW-1:0]]};
      4'd3: rd_word = {25'd0, status};
      4'd4: rd_word = {16'd0, baud};
      4'd5: rd_word = {28'd0, irq_en};
      default: rd_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out    <= 32'd0;
      tx_en       <= 1'b0;
      rx_en       <= 1'b0;
      par_en      <= 1'b0;
      par_odd     <= 1'b0;
      baud        <= DIV_INIT;
      irq_en      <= 4'd0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      tx_wp       <= '0;
      tx_rp       <= '0;
      rx_wp       <= '0;
      rx_rp       <= '0;
    end else begin
      if (read_enable) data_out <= rd_word;
      if (wr_ctrl) begin
        tx_en <= data_in[0];
        rx_en <= data_in[1];
`ifdef UART_PARITY_EN
        par_en  <= data_in[3];
        par_odd <= data_in[4];
`endif
      end
      if (wr_baud)  baud   <= (data_in[15:0] < 16'd4) ? 16'd4 : data_in[15:0];
      if (wr_irqen) irq_en <= data_in[3:0];
      // Set has priority over a same-cycle write-1-to-clear.
      overrun     <= overrun_set | (overrun     & ~(wr_stat & data_in[2]));
      framing_err <= rx_ferr     | (framing_err & ~(wr_stat & data_in[3]));
      parity_err  <= rx_perr     | (parity_err  & ~(wr_stat & data_in[6]));
      if (flush) begin
        tx_wp <= '0;
        tx_rp <= '0;
        rx_wp <= '0;
        rx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + TX_ONE;
        if (tx_pop)  tx_rp <= tx_rp + TX_ONE;
        if (rx_push) rx_wp <= rx_wp + RX_ONE;
        if (rx_pop)  rx_rp <= rx_rp + RX_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= data_in[DATA_BITS-1:0];
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state  <= S_IDLE;
      tx        <= 1'b1;
      tx_cnt    <= '0;
      tx_div    <= DIV_INIT;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_par_on <= 1'b0;
    end else if (tx_pop) begin
      tx_state  <= S_START;
      tx        <= 1'b0;
      tx_cnt    <= '0;
      tx_div    <= baud;
      tx_shift  <= tx_head;
      tx_par    <= (^tx_head) ^ par_odd;
      tx_par_on <= par_en;
    end else if (tx_state != S_IDLE) begin
      if (!tx_last) begin
        tx_cnt <= tx_cnt + 16'd1;
      end else begin
        tx_cnt <= '0;
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            tx       <= tx_shift[0];
            tx_bit   <= '0;
          end
          S_DATA: begin
            if (tx_bit == LAST_BIT) begin
              tx_state <= tx_par_on ? S_PARITY : S_STOP;
              tx       <= tx_par_on ? tx_par : 1'b1;
            end else begin
              tx_bit   <= tx_bit + BIT_ONE;
              tx_shift <= tx_shift >> 1;
              tx       <= tx_shift[1];
            end
          end
          S_PARITY: begin
            tx_state <= S_STOP;
            tx       <= 1'b1;
          end
          default: begin
            tx_state <= S_IDLE;
            tx       <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_div    <= DIV_INIT;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_par_on <= 1'b0;
      rx_odd    <= 1'b0;
      rx_pbad   <= 1'b0;
      rx_done   <= 1'b0;
      rx_ferr   <= 1'b0;
      rx_perr   <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_done <= 1'b0;
      rx_ferr <= 1'b0;
      rx_perr <= 1'b0;
      if (!rx_en) begin
        rx_state <= S_IDLE;
      end else begin
        case (rx_state)
          S_IDLE: begin
            if (rx_prev && !rx_s2) begin
              rx_state  <= S_START;
              rx_cnt    <= '0;
              rx_div    <= baud;
              rx_par_on <= par_en;
              rx_odd    <= par_odd;
              rx_pbad   <= 1'b0;
            end
          end
          S_START: begin
            // Half a bit in: a high line means the edge was a glitch.
            if (rx_cnt == (rx_div >> 1) - 16'd1) begin
              rx_state <= rx_s2 ? S_IDLE : S_DATA;
              rx_cnt   <= '0;
              rx_bit   <= '0;
            end else begin
              rx_cnt <= rx_cnt + 16'd1;
            end
          end
          S_DATA: begin
            if (rx_last) begin
              rx_cnt   <= '0;
              rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
              rx_bit   <= rx_bit + BIT_ONE;
              if (rx_bit == LAST_BIT) rx_state <= rx_par_on ? S_PARITY : S_STOP;
            end else begin
              rx_cnt <= rx_cnt + 16'd1;
            end
          end
          S_PARITY: begin
            if (rx_last) begin
              rx_cnt   <= '0;
              rx_pbad  <= (rx_s2 != ((^rx_shift) ^ rx_odd));
              rx_state <= S_STOP;
            end else begin
              rx_cnt <= rx_cnt + 16'd1;
            end
          end
          default: begin
            if (rx_last) begin
              rx_cnt   <= '0;
              rx_state <= S_IDLE;
              rx_ferr  <= !rx_s2;
              rx_perr  <= rx_par_on && rx_pbad;
              rx_done  <= rx_s2 && !(rx_par_on && rx_pbad);
            end else begin
              rx_cnt <= rx_cnt + 16'd1;
            end
          end
        endcase
      end
    end
  end
endmodule
